// File: rtl/store_aligner_if.sv
// Store aligner bus bundle: store request stream in, memory write beats out.
// master = EX/MEM producer plus memory; slave = store_aligner.
interface store_aligner_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_fun_3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;

    modport master (
        output req_valid, req_fun_3, req_addr, req_data, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb
    );

    modport slave (
        input  req_valid, req_fun_3, req_addr, req_data, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/store_aligner.sv
// MEM-stage store aligner: lane-shifts sb/sh/sw data, builds byte strobes,
// splits word-crossing stores into two beats.
// Ports: clk, rst_n (async low), bus (store_aligner_if.slave),
//        busy (not idle), err (1-cycle pulse on illegal funct3 accept).
module store_aligner #(
    parameter int ADDR_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    store_aligner_if.slave  bus,
    output logic            busy,
    output logic            err
);

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1
    } state_t;

    state_t state, state_d;

    logic [1:0]  off_q;
    logic [3:0]  mask_q;
    logic [31:0] data_q;
    logic        split_q;

    logic [1:0]  off_in;
    logic [3:0]  mask_in;
    logic [7:0]  strb_wide;
    logic        split_in;
    logic        legal;

    logic        fire;
    logic        last;
    logic        accept;
    logic        load_req;
    logic        load_hi;

    logic [5:0]  hi_shift;
    logic [2:0]  hi_lane;

    assign off_in = bus.req_addr[1:0];

    always_comb begin
        mask_in = 4'b0000;
        legal   = 1'b0;
        unique case (1'b1)
            (bus.req_fun_3 == 3'b000): begin
                mask_in = 4'b0001;
                legal   = 1'b1;
            end
            (bus.req_fun_3 == 3'b001): begin
                mask_in = 4'b0011;
                legal   = 1'b1;
            end
            (bus.req_fun_3 == 3'b010): begin
                mask_in = 4'b1111;
                legal   = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes spilling into the upper nibble mean the store crosses
    // into the next word.
    assign strb_wide = {4'b0000, mask_in} << off_in;
    assign split_in  = |strb_wide[7:4];

    assign fire = bus.mem_valid && bus.mem_ready;
    assign last = (state == BEAT1) || ((state == BEAT0) && !split_q);

    assign bus.req_ready = (state == IDLE) || (fire && last);
    assign accept        = bus.req_valid && bus.req_ready;

    assign bus.mem_valid = (state != IDLE);
    assign busy          = (state != IDLE);

    assign hi_shift = 6'd32 - {1'b0, off_q, 3'b000};
    assign hi_lane  = 3'd4 - {1'b0, off_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d  = state;
        load_req = 1'b0;
        load_hi  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept && legal) begin
                    state_d  = BEAT0;
                    load_req = 1'b1;
                end
            end
            BEAT0, BEAT1: begin
                if (fire) begin
                    if (!last) begin
                        state_d = BEAT1;
                        load_hi = 1'b1;
                    end else if (accept && legal) begin
                        state_d  = BEAT0;
                        load_req = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q         <= 2'b00;
            mask_q        <= 4'b0000;
            data_q        <= 32'h0;
            split_q       <= 1'b0;
            err           <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= 32'h0;
            bus.mem_wstrb <= 4'b0000;
        end else begin
            err <= accept && !legal;
            if (load_req) begin
                off_q         <= off_in;
                mask_q        <= mask_in;
                data_q        <= bus.req_data;
                split_q       <= split_in;
                bus.mem_addr  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                bus.mem_wdata <= bus.req_data << {off_in, 3'b000};
                bus.mem_wstrb <= strb_wide[3:0];
            end else if (load_hi) begin
                // Second beat carries the bytes that fell off the top.
                bus.mem_addr  <= bus.mem_addr + ADDR_W'(4);
                bus.mem_wdata <= data_q >> hi_shift;
                bus.mem_wstrb <= mask_q >> hi_lane;
            end
        end
    end

endmodule

// File: tb/tb_store_aligner.sv
// Testbench for store_aligner: directed scenarios plus random traffic
// checked against a byte-lane scoreboard model.
module tb_store_aligner;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic err;

    store_aligner_if #(.ADDR_W(32)) sif ();

    store_aligner #(.ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } beat_t;

    beat_t q[$];

    // Model: place the store bytes into a 64-bit window starting at the
    // word address; each nonempty word of that window is one beat.
    task automatic model_push(input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] data);
        int          sz;
        int          off;
        logic [7:0]  m8;
        logic [63:0] full;
        logic [31:0] base;
        beat_t       b;
        sz   = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        off  = int'(addr[1:0]);
        m8   = 8'((1 << sz) - 1) << off;
        full = {32'h0, data} << (8 * off);
        base = {addr[31:2], 2'b00};
        b.a = base;
        b.d = full[31:0];
        b.s = m8[3:0];
        q.push_back(b);
        if (m8[7:4] != 4'h0) begin
            b.a = base + 32'd4;
            b.d = full[63:32];
            b.s = m8[7:4];
            q.push_back(b);
        end
    endtask

    logic  err_pend = 1'b0;
    logic  prev_stall = 1'b0;
    beat_t held;
    beat_t got_b;
    beat_t exp_b;
    int    n_out;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            err_pend   = 1'b0;
            prev_stall = 1'b0;
            check("rst_valid", sif.mem_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_err", err, 0);
            check("rst_addr", sif.mem_addr, 0);
            check("rst_wdata", sif.mem_wdata, 0);
            check("rst_wstrb", sif.mem_wstrb, 0);
        end else begin
            n_out = q.size();
            check("valid", sif.mem_valid, (n_out != 0) ? 1 : 0);
            check("busy", busy, (n_out != 0) ? 1 : 0);
            check("req_ready", sif.req_ready,
                  ((n_out == 0) || (sif.mem_ready && n_out == 1)) ? 1 : 0);
            check("err", err, err_pend);
            got_b.a = sif.mem_addr;
            got_b.d = sif.mem_wdata;
            got_b.s = sif.mem_wstrb;
            if (prev_stall) begin
                check("stable", got_b, held);
            end
            if (sif.mem_valid && sif.mem_ready && n_out != 0) begin
                exp_b = q.pop_front();
                check("beat_addr", got_b.a, exp_b.a);
                check("beat_wdata", got_b.d, exp_b.d);
                check("beat_wstrb", got_b.s, exp_b.s);
            end
            err_pend = sif.req_valid && sif.req_ready && (sif.req_fun_3 > 3'd2);
            if (sif.req_valid && sif.req_ready && sif.req_fun_3 <= 3'd2) begin
                model_push(sif.req_fun_3, sif.req_addr, sif.req_data);
            end
            prev_stall = sif.mem_valid && !sif.mem_ready;
            held       = got_b;
        end
    end

    task automatic send(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d);
        bit done;
        done = 1'b0;
        sif.req_valid = 1'b1;
        sif.req_fun_3 = f3;
        sif.req_addr  = a;
        sif.req_data  = d;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (sif.req_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        sif.req_valid = 1'b0;
        check("send_accepted", done, 1);
    endtask

    task automatic expect_beat(input string tag, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] s,
                               output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (sif.mem_valid && sif.mem_ready) begin
                seen = 1'b1;
                check({tag, "_addr"}, sif.mem_addr, a);
                check({tag, "_wdata"}, sif.mem_wdata, d);
                check({tag, "_wstrb"}, sif.mem_wstrb, s);
            end
        end
        check({tag, "_seen"}, seen, 1);
        @(posedge clk);
        #1;
    endtask

    int lat;
    logic [31:0] ra;

    initial begin
        sif.req_valid = 1'b0;
        sif.req_fun_3 = 3'd0;
        sif.req_addr  = 32'h0;
        sif.req_data  = 32'h0;
        sif.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // sb at offset 3
        send(3'b000, 32'h103, 32'h000000AB);
        expect_beat("sb", 32'h100, 32'hAB000000, 4'b1000, lat);
        check("sb_latency", lat, 1);
        #0;
        check("sb_one_cycle", sif.mem_valid, 0);

        // word-crossing sw
        send(3'b010, 32'h202, 32'hDDCCBBAA);
        @(negedge clk);
        check("split_b0_ready", sif.req_ready, 0);
        check("split_b0_valid", sif.mem_valid, 1);
        check("split_b0_addr", sif.mem_addr, 32'h200);
        check("split_b0_wdata", sif.mem_wdata, 32'hBBAA0000);
        check("split_b0_wstrb", sif.mem_wstrb, 4'b1100);
        @(posedge clk);
        #1;
        expect_beat("split_b1", 32'h204, 32'h0000DDCC, 4'b0011, lat);
        check("split_b1_latency", lat, 1);

        // backpressure on sh
        sif.mem_ready = 1'b0;
        send(3'b001, 32'h0, 32'h00001234);
        repeat (3) begin
            @(negedge clk);
            check("bp_valid", sif.mem_valid, 1);
            check("bp_wdata", sif.mem_wdata, 32'h00001234);
            check("bp_wstrb", sif.mem_wstrb, 4'b0011);
        end
        @(posedge clk);
        #1;
        sif.mem_ready = 1'b1;
        expect_beat("bp", 32'h0, 32'h00001234, 4'b0011, lat);
        check("bp_latency", lat, 1);

        // back-to-back aligned sw
        for (int i = 0; i < 3; i++) begin
            sif.req_valid = 1'b1;
            sif.req_fun_3 = 3'b010;
            sif.req_addr  = 32'h10 + 32'(4 * i);
            sif.req_data  = 32'hC0DE0000 + 32'(i);
            @(negedge clk);
            check("b2b_ready", sif.req_ready, 1);
            @(posedge clk);
            #1;
        end
        sif.req_valid = 1'b0;
        @(negedge clk);
        check("b2b_last_valid", sif.mem_valid, 1);
        check("b2b_last_addr", sif.mem_addr, 32'h18);
        check("b2b_last_wstrb", sif.mem_wstrb, 4'b1111);
        @(posedge clk);
        #1;

        // illegal funct3
        send(3'b011, 32'h44, 32'hFFFFFFFF);
        @(negedge clk);
        check("ill_err", err, 1);
        check("ill_valid", sif.mem_valid, 0);
        @(negedge clk);
        check("ill_err_drop", err, 0);
        @(posedge clk);
        #1;
        send(3'b000, 32'h40, 32'h00000011);
        expect_beat("after_ill", 32'h40, 32'h00000011, 4'b0001, lat);

        // reset after beat 0 of a split sh
        send(3'b001, 32'h303, 32'h00005566);
        expect_beat("rst_b0", 32'h300, 32'h66000000, 4'b1000, lat);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", sif.mem_valid, 0);
        check("rst_mid_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("rst_no_b1", sif.mem_valid, 0);
        end
        @(posedge clk);
        #1;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n         = ($urandom_range(0, 399) != 0);
            sif.req_valid = ($urandom_range(0, 3) != 0);
            sif.req_fun_3 = ($urandom_range(0, 7) == 0) ?
                            3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'hFFFFFFFC | (ra & 32'h3);
            sif.req_addr  = ra;
            sif.req_data  = $urandom;
            sif.mem_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
        end
        rst_n         = 1'b1;
        sif.req_valid = 1'b0;
        sif.mem_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("drain_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/store_aligner.md
Name: store_aligner

Overview:
- Store-side counterpart of the load filter in the MEM stage.
- Takes a store request (funct3, byte address, rs2 data) from EX/MEM and drives the data-memory write port. Shifts data into byte lanes and generates per-byte write strobes.
- Splits misaligned sh/sw stores that cross a word boundary into two word-aligned bus beats.
- Uses a valid/ready handshake on both sides and holds one request in flight.

Parameters:
- ADDR_W, 32, byte-address width. Memory addresses are word-aligned (bits [1:0] forced to 0).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  store request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_fun_3  in  3  funct3 of the store: 000 sb, 001 sh, 010 sw.
- req_addr  in  ADDR_W  byte address.
- req_data  in  32  rs2 store data, right-justified.
- mem_valid  out  1  write beat valid.
- mem_ready  in  1  memory accepts the beat when mem_valid && mem_ready.
- mem_addr  out  ADDR_W  word-aligned beat address.
- mem_wdata  out  32  lane-shifted write data.
- mem_wstrb  out  4  byte enables; bit i enables mem_wdata[8i+7:8i].
- busy  out  1  high whenever state != IDLE.
- err  out  1  one-cycle pulse when a request with an illegal funct3 is accepted.

Behaviour:

Reset (asynchronous, rst_n=0):
- State goes to IDLE.
- mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, err=0, busy=0.
- Any in-flight request is dropped, including one where beat 0 has already completed.

Handshake:
- States are IDLE, BEAT0, BEAT1.
- req_ready = (state==IDLE) || (mem_valid && mem_ready && this is the final beat).
- This allows back-to-back aligned stores at 1 per cycle.

Accept (at the edge where req_valid && req_ready):
- Latch off=req_addr[1:0], funct3, data, and word address A={req_addr[ADDR_W-1:2],2'b00}.
- Mask m: sb 0001, sh 0011, sw 1111.
- Split condition: (off + size) > 4, where size is 1/2/4 bytes. This covers sh at off 3 and sw at off 1/2/3.
- Legal funct3: next state BEAT0. The mem_* outputs are registered and appear the next cycle, so latency from accept to mem_valid=1 is 1 cycle.
- Illegal funct3 (anything other than 000/001/010): no beat is issued, err=1 for exactly the next cycle, and the state stays IDLE (or returns to it).

BEAT0:
- mem_addr=A.
- mem_wdata=(data << 8*off)[31:0].
- mem_wstrb=(m << off)[3:0].
- If mem_valid && mem_ready:
  - Split: go to BEAT1.
  - Not split: go to IDLE, or directly to BEAT0 if a new request is accepted in the same cycle.

BEAT1 (split only):
- mem_addr=A+4, wrapping modulo 2^ADDR_W.
- mem_wdata=data >> 8*(4-off).
- mem_wstrb=m >> (4-off).
- On handshake, treat it as the final beat: same next-state rules as a non-split BEAT0.

Stability and general rules:
- While mem_valid && !mem_ready, all mem_* outputs hold stable, with no limit on wait cycles.
- mem_valid never drops without a handshake, except on reset.
- Bytes not enabled in mem_wdata are don't-care; the implementation drives them as the shifted value.
- A sb store never splits.
- Aligned sw at off 0 gives strobe 1111 in a single beat.

Test Plan:
- sb: addr 0x103, data 0x000000AB, mem_ready=1 -> one beat at 0x100, wdata 0xAB000000, wstrb 1000; mem_valid high exactly 1 cycle, 1 cycle after accept.
- sw split: addr 0x202, data 0xDDCCBBAA, mem_ready=1 -> beat 0x200 with wdata 0xBBAA0000, wstrb 1100; then beat 0x204 with wdata 0x0000DDCC, wstrb 0011; req_ready low during beat 0.
- Backpressure: sh at addr 0x0, data 0x1234, mem_ready=0 for 3 cycles -> mem_addr 0x0, wdata 0x00001234, wstrb 0011 held constant for 4 cycles, completing on the 4th.
- Back-to-back: three aligned sw requests on consecutive cycles (addrs 0x10, 0x14, 0x18), mem_ready=1 -> three consecutive beats, req_ready high every cycle.
- Illegal funct3=011 -> no mem_valid, err=1 for exactly 1 cycle, next request accepted normally.
- Reset mid-split: drop rst_n after the beat-0 handshake of an sh at off 3 -> mem_valid=0 immediately, state IDLE, no beat-1 write after rst_n returns high.
